ps2_kbd_tx: RTL and testbench

Device-side PS/2 keyboard transmitter. It is the sending end of the ps2_clk/ps2_data link that the board top-level receives. It accepts scan-code bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises each byte as a standard 11-bit PS/2 frame, generating both ps2_clk and ps2_data. It is used to drive the top-level PS/2 inputs in simulation and loopback tests, and as a keyboard emulator on the board.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_kbd_tx_fifo.sv | 65 ++++++
 rtl/ps2_kbd_tx.sv | 133 +++++++++++++
 tb/tb_ps2_kbd_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and helpers for the PS/2 keyboard transmitter.
// Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ps2_state_t;

    // PS/2 parity bit: makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_kbd_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync
// Description : Single-clock FIFO with occupancy counter and
//               combinational read port (dout shows the head entry).
// Revision    : 1.0  initial release
// ============================================================================
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_depth = (c_addr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_do_push;
    logic                w_do_pop;

    // Requests against a full/empty buffer are silently dropped.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_tx
// Description : Device-side PS/2 keyboard transmitter. Buffers scan-code
//               bytes and sends each as an 11-bit frame, driving both
//               ps2_clk and ps2_data from registers, with an idle gap
//               after every frame.
// Revision    : 1.0  initial release
// ============================================================================
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 10000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int c_ph_w  = $clog2(2 * CLK_DIV);
    localparam int c_gap_w = $clog2(GAP_CYCLES + 1);

    // Phase value after which ps2_clk drops, and the last phase of a bit.
    localparam logic [c_ph_w-1:0]  c_ph_fall  = c_ph_w'(CLK_DIV - 1);
    localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(2 * CLK_DIV - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
    localparam logic [3:0]         c_last_bit = 4'(PS2_FRAME_BITS - 1);

    ps2_state_t          r_state;
    logic [c_ph_w-1:0]   r_phase;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic [3:0]          r_bit_idx;
    // Bits still to send after the start bit: data[7:0], parity, stop.
    logic [PS2_FRAME_BITS-2:0] r_shift;
    logic                r_ps2_clk;
    logic                r_ps2_data;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_head;

    assign w_push   = in_valid && !w_full;
    assign w_pop    = (r_state == IDLE) && !w_empty;
    assign in_ready = !w_full;
    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;
    assign busy     = (r_state != IDLE) || !w_empty;

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Frame sequencer: pops a byte, shifts it out bit by bit, then idles for the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_gap_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ps2_clk  <= 1'b1;
                    r_ps2_data <= 1'b1;
                    if (!w_empty) begin
                        r_shift    <= {1'b1, odd_parity(w_head), w_head};
                        r_ps2_data <= 1'b0;
                        r_bit_idx  <= '0;
                        r_phase    <= '0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_phase == c_ph_last) begin
                        // End of bit: clock back high, data moves on while clock is high.
                        r_phase   <= '0;
                        r_ps2_clk <= 1'b1;
                        if (r_bit_idx == c_last_bit) begin
                            r_ps2_data <= 1'b1;
                            r_gap_cnt  <= '0;
                            r_state    <= GAP;
                        end else begin
                            r_bit_idx  <= r_bit_idx + 4'd1;
                            r_ps2_data <= r_shift[0];
                            r_shift    <= {1'b1, r_shift[PS2_FRAME_BITS-2:1]};
                        end
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                        if (r_phase == c_ph_fall) begin
                            r_ps2_clk <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_ps2_clk  <= 1'b1;
                    r_ps2_data <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_tx
// Description : Self-checking bench for ps2_kbd_tx. Stimulus queues the
//               expected bytes; a receiver monitor decodes frames from the
//               PS/2 lines and compares them against the queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_kbd_tx;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic       par;
        logic [7:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    // Receiver monitor state
    int          frames_done = 0;
    int          mon_bits = 0;
    logic        mon_active = 1'b0;
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;
    logic [10:0] rx;
    int          start_cyc = 0;
    int          end_cyc = 0;
    int          fall_cyc = 0;
    int          last_gap = 0;
    int          spacing_bad = 0;

    ps2_kbd_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural PS/2 receiver: samples data on each falling ps2_clk.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            mon_bits   = 0;
            prev_clk   = 1'b1;
            prev_data  = 1'b1;
        end else begin
            if (!mon_active && prev_data && !ps2_data && ps2_clk) begin
                mon_active  = 1'b1;
                mon_bits    = 0;
                spacing_bad = 0;
                last_gap    = cyc - end_cyc;
                start_cyc   = cyc;
            end
            if (prev_clk && !ps2_clk) begin
                if (!mon_active || mon_bits > 10) begin
                    check("stray ps2_clk fall", 0, 1);
                end else begin
                    if (mon_bits == 0) check("first fall latency", cyc - start_cyc, CLK_DIV);
                    else if (cyc - fall_cyc != 2 * CLK_DIV) spacing_bad++;
                    rx[mon_bits] = ps2_data;
                    mon_bits++;
                    fall_cyc = cyc;
                end
            end
            if (!prev_clk && ps2_clk && mon_active && mon_bits == 11) begin
                mon_active = 1'b0;
                end_cyc    = cyc;
                check("fall spacing errors", spacing_bad, 0);
                check("frame length", end_cyc - start_cyc, 22 * CLK_DIV);
                if (exp_q.size() == 0) begin
                    check("unexpected frame", {21'd0, rx}, 32'h7ff);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame bits", {21'd0, rx}, {21'd0, 1'b1, e.par, e.b, 1'b0});
                end
                frames_done++;
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offer one byte, hold it until accepted, and queue its expected frame.
    task automatic send(input logic [7:0] b, input logic p);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 5000) begin
            step();
            n++;
        end
        check("send handshake", in_ready, 1);
        exp_q.push_back('{par: p, b: b});
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            step();
            n++;
        end
        check("frames received in time", frames_done >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check("returns idle in time", busy, 0);
    endtask

    initial begin
        int   fd0;
        int   acc;
        int   toggles;
        logic rdy10;
        logic pc;
        logic pd;

        // Reset state
        repeat (3) step();
        check("reset ps2_clk", ps2_clk, 1);
        check("reset ps2_data", ps2_data, 1);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // Single byte 0x1C: 0,0,0,1,1,1,0,0,0,0,1
        fd0 = frames_done;
        send(8'h1C, 1'b0);
        wait_frames(fd0 + 1, 400);
        while (cyc < end_cyc + GAP_CYCLES - 1) step();
        check("busy during gap", busy, 1);
        step();
        check("busy after gap", busy, 0);

        // 0xF0 then 0x1C back-to-back
        fd0 = frames_done;
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b0);
        wait_frames(fd0 + 2, 600);
        check("back-to-back gap", last_gap, GAP_CYCLES + 1);
        wait_idle(200);

        // Overflow: 12 cycles of in_valid, bytes 0x01..0x0C
        fd0 = frames_done;
        acc = 0;
        rdy10 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            if (i == 10) rdy10 = in_ready;
            if (in_ready) begin
                logic [7:0] bi;
                bi = 8'(i);
                exp_q.push_back('{par: ~(^bi), b: bi});
                acc++;
            end
            step();
        end
        in_valid = 1'b0;
        check("overflow accepted count", acc, 9);
        check("in_ready low when full", rdy10, 0);
        wait_frames(fd0 + 1, 400);
        while (cyc < end_cyc + GAP_CYCLES) step();
        check("in_ready before pop", in_ready, 0);
        step();
        check("in_ready on pop", in_ready, 1);
        wait_frames(fd0 + 9, 2000);
        wait_idle(200);

        // Reset mid-frame with two bytes queued
        begin
            int n = 0;
            send(8'h55, 1'b1);
            send(8'hAA, 1'b1);
            send(8'h33, 1'b1);
            while (mon_bits < 5 && n < 500) begin
                step();
                n++;
            end
            check("reached bit 4", mon_bits >= 5, 1);
        end
        rst = 1'b1;
        step();
        check("abort ps2_clk", ps2_clk, 1);
        check("abort ps2_data", ps2_data, 1);
        check("abort busy", busy, 0);
        exp_q.delete();
        rst = 1'b0;
        toggles = 0;
        pc = ps2_clk;
        pd = ps2_data;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ps2_clk != pc || ps2_data != pd) toggles++;
            pc = ps2_clk;
            pd = ps2_data;
        end
        check("line activity after abort", toggles, 0);
        check("busy after abort", busy, 0);

        // Random stress: 200 bytes, random idle gaps between offers
        fd0 = frames_done;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] rb;
            rb = 8'($urandom_range(0, 255));
            send(rb, ~(^rb));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_frames(fd0 + 200, 30000);
        check("stress frame count", frames_done - fd0, 200);
        check("scoreboard drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
